// File: rtl/uart_rx_pkg.sv
// Shared definitions for the COM-link receiver: state encodings, default
// line parameters and the 2-of-3 majority helper.
package uart_rx_pkg;

  localparam int RX_STATE_WIDTH = 3;

  typedef enum logic [RX_STATE_WIDTH-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

  localparam int DEF_CLK_FREQ   = 11059200;
  localparam int DEF_BAUD       = 115200;
  localparam int DEF_OVERSAMPLE = 16;

  // Bit value decided from three mid-bit samples; one corrupted sample is outvoted.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-facing signal bundle: raw serial line in, received byte and status out.
interface uart_rx_if;
  logic       com_RxD;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_error;
  logic       busy;

  modport master (output com_RxD, input data_out, data_ready, frame_error, busy);
  modport slave  (input com_RxD, output data_out, data_ready, frame_error, busy);
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// Oversampling tick source: one-cycle tick every DIVISOR clocks, with a
// synchronous restart so the tick phase can be aligned to a start edge.
module baud_tick_gen #(
  parameter int DIVISOR = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap after LAST, or jump back to 0 on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_rx.sv
// COM-link serial receiver: synchronises the line, oversamples each bit,
// majority-votes the mid-bit samples and validates start and stop bits.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int DIVISOR = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TCW     = $clog2(OVERSAMPLE);
  // tc counts ticks already elapsed in the bit, so the tick that brings the
  // bit to its 7th/8th/9th tick (at OVERSAMPLE=16) sees tc = 6/7/8.
  localparam logic [TCW-1:0] TC_S0  = TCW'(OVERSAMPLE/2 - 2);
  localparam logic [TCW-1:0] TC_S1  = TCW'(OVERSAMPLE/2 - 1);
  localparam logic [TCW-1:0] TC_DEC = TCW'(OVERSAMPLE/2);
  localparam logic [TCW-1:0] TC_END = TCW'(OVERSAMPLE - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and >= 8");
  end
  if (DIVISOR < 2 || (CLK_FREQ % (BAUD * OVERSAMPLE)) != 0) begin : g_bad_div
    $error("uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be a whole number >= 2");
  end

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs, tick, restart, maj;
  logic          decide, bit_end;
  logic [TCW-1:0] tc_q;
  logic [2:0]    bidx_q;
  logic [7:0]    shreg_q;
  logic          smp0_q, smp1_q;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_ready_q, data_ready_d;
  logic          frame_error_q, frame_error_d;

  // Two-flop synchroniser on the raw line; idles at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.com_RxD};
  end
  assign rxs = sync_q[1];

  assign restart = (state_q == IDLE) && !rxs;
  assign decide  = tick && (tc_q == TC_DEC);
  assign bit_end = tick && (tc_q == TC_END);
  assign maj     = maj3(smp0_q, smp1_q, rxs);

  baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rxs) state_d = START;
      START: begin
        if (decide && maj) state_d = IDLE;
        else if (bit_end)  state_d = DATA;
      end
      DATA:  if (bit_end && (bidx_q == 3'd7)) state_d = STOP;
      STOP:  if (decide) state_d = maj ? IDLE : BRK;
      BRK:   if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: byte hand-off or framing error at the stop-bit decision.
  always_comb begin
    data_out_d    = data_out_q;
    data_ready_d  = 1'b0;
    frame_error_d = 1'b0;
    if ((state_q == STOP) && decide) begin
      if (maj) begin
        data_ready_d = 1'b1;
        data_out_d   = shreg_q;
      end else begin
        frame_error_d = 1'b1;
      end
    end
  end

  // Registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q    <= 8'h00;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      data_out_q    <= data_out_d;
      data_ready_q  <= data_ready_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Bit timing, mid-bit samples and LSB-first shift register; held clear while idle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      tc_q   <= '0;
      bidx_q <= 3'd0;
    end else if (tick) begin
      tc_q <= (tc_q == TC_END) ? '0 : tc_q + 1'b1;
      if (tc_q == TC_S0) smp0_q <= rxs;
      if (tc_q == TC_S1) smp1_q <= rxs;
      if ((state_q == DATA) && (tc_q == TC_DEC)) shreg_q <= {maj, shreg_q[7:1]};
      if ((state_q == DATA) && (tc_q == TC_END)) bidx_q  <= bidx_q + 3'd1;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_ready  = data_ready_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (96 clocks per bit).
module tb_uart_rx;
  localparam int BIT = 96;

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] rxq[$];
  int         rx_cyc[$];
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         busy_rise = -1;
  int         busy_fall = -1;
  logic       busy_prev = 1'b0;
  int         t0 = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.data_ready) begin
      rxq.push_back(bus.data_out);
      rx_cyc.push_back(cyc);
    end
    if (bus.frame_error) fe_cnt++;
    if (bus.data_ready && bus.frame_error) both_cnt++;
    if (bus.busy && !busy_prev) busy_rise = cyc;
    if (!bus.busy && busy_prev) busy_fall = cyc;
    busy_prev = bus.busy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold one line level for len cycles, inverting it for the single cycle at goff (if >= 0).
  task automatic send_bit(input logic v, input int len, input int goff);
    for (int i = 0; i < len; i++) begin
      bus.com_RxD = (i == goff) ? ~v : v;
      @(posedge clk); #1;
    end
    bus.com_RxD = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input int len, input logic stopv,
                           input int gbase, input int gstep);
    t0 = cyc + 1;
    send_bit(1'b0, len, (gbase < 0) ? -1 : gbase);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], len, (gbase < 0) ? -1 : gbase + gstep * (i + 1));
    send_bit(stopv, len, (gbase < 0) ? -1 : gbase + gstep * 9);
  endtask

  task automatic idle(input int n);
    send_bit(1'b1, n, -1);
  endtask

  initial begin
    int n0;
    logic [7:0] b2b[6];
    b2b = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00};

    rst = 1'b1;
    bus.com_RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_ready", bus.data_ready, 0);
    chk("rst_ferr", bus.frame_error, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    idle(10);

    // Plain byte: latency, busy window, no error.
    send_byte(8'h70, BIT, 1'b1, -1, 0);
    idle(20);
    chk("t1_count", rxq.size(), 1);
    if (rxq.size() >= 1) begin
      chk("t1_data", rxq[0], 8'h70);
      chk("t1_lat_in_921pm1", int'((rx_cyc[0] - t0) >= 920 && (rx_cyc[0] - t0) <= 922), 1);
      chk("t1_busy_fall_with_ready", busy_fall, rx_cyc[0]);
    end
    chk("t1_busy_rise", busy_rise - t0, 2);
    chk("t1_ferr", fe_cnt, 0);

    // 12-cycle low glitch is a false start.
    t0 = cyc + 1;
    send_bit(1'b0, 12, -1);
    idle(100);
    chk("t2_busy_rose", busy_rise - t0, 2);
    chk("t2_busy_fall_60", int'(busy_fall > t0 && (busy_fall - t0) <= 60), 1);
    chk("t2_no_ready", rxq.size(), 1);
    chk("t2_no_ferr", fe_cnt, 0);

    // Stop bit low, then a held break, then a good byte.
    send_byte(8'h0F, BIT, 1'b0, -1, 0);
    send_bit(1'b0, 300, -1);
    chk("t3_ferr_once", fe_cnt, 1);
    chk("t3_no_ready", rxq.size(), 1);
    chk("t3_data_kept", bus.data_out, 8'h70);
    chk("t3_busy_in_break", bus.busy, 1);
    idle(30);
    chk("t3_busy_released", bus.busy, 0);
    send_byte(8'h38, BIT, 1'b1, -1, 0);
    idle(20);
    chk("t3_next_count", rxq.size(), 2);
    if (rxq.size() >= 2) chk("t3_next_data", rxq[1], 8'h38);
    chk("t3_ferr_still_once", fe_cnt, 1);

    // Back-to-back bytes with no idle gap.
    n0 = rxq.size();
    for (int i = 0; i < 6; i++) send_byte(b2b[i], BIT, 1'b1, -1, 0);
    idle(20);
    chk("t4_count", rxq.size(), n0 + 6);
    for (int i = 0; i < 6; i++)
      if (rxq.size() > n0 + i) chk($sformatf("t4_byte%0d", i), rxq[n0 + i], b2b[i]);

    // 3 % fast line with a glitch on the first sample of every bit.
    n0 = rxq.size();
    send_byte(8'h93, 93, 1'b1, 42, 3);
    idle(40);
    chk("t5_count", rxq.size(), n0 + 1);
    if (rxq.size() > n0) chk("t5_data", rxq[n0], 8'h93);
    chk("t5_ferr", fe_cnt, 1);

    // Reset during data bit 4 of 0xF3, then a clean 0xF3.
    n0 = rxq.size();
    send_bit(1'b0, BIT, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & 8'hF3 >> i, BIT, -1);
    send_bit(1'b1, 40, -1);
    rst = 1'b1;
    #1;
    chk("t6_async_data_out", bus.data_out, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_ready", bus.data_ready, 0);
    chk("t6_async_ferr", bus.frame_error, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    send_bit(1'b1, BIT - 42, -1);
    for (int i = 5; i < 8; i++) send_bit(1'b1, BIT, -1);
    send_bit(1'b1, BIT, -1);
    idle(20);
    chk("t6_no_pulse", rxq.size(), n0);
    send_byte(8'hF3, BIT, 1'b1, -1, 0);
    idle(20);
    chk("t6_next_count", rxq.size(), n0 + 1);
    if (rxq.size() > n0) chk("t6_next_data", rxq[n0], 8'hF3);

    chk("never_ready_and_ferr", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the board's COM link. It oversamples `com_RxD` and validates start and stop bits. Each correctly framed byte is presented to the command/transfer controller as `data_out` with a one-cycle `data_ready` strobe. It sits directly upstream of the transfer controller's receive path, and its strobe and byte drive that controller's byte-shift register and frame counter.

## Interface
Parameters:
- `CLK_FREQ`, 11059200: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bits per second.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 8.
- `DIVISOR` (derived), `CLK_FREQ/(BAUD*OVERSAMPLE)`, which is 6 at the defaults. It must be a whole number ≥ 2; this is checked at elaboration.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `com_RxD`  in  1  raw serial line. Idle level is 1.
- `data_out`  out  8  last correctly received byte, LSB first on the line.
- `data_ready`  out  1  one-cycle pulse when `data_out` is updated.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `busy`  out  1  high from start-bit detection until the receiver returns to IDLE.

## Operation
- Input synchroniser: two flops, both reset to 1. All logic uses only the synchronised `rxs`.
- Tick generator: a free-running counter of width clog2(DIVISOR) that issues `tick` for one cycle every DIVISOR cycles. It reloads to 0 when IDLE detects a falling edge, so the bit phase aligns to the start edge.
- Bit sampling: a tick counter `tc` (0..OVERSAMPLE-1) runs within each bit. On ticks OVERSAMPLE/2-1, /2 and /2+1 (7, 8, 9 at the defaults) the receiver samples `rxs` and takes a 2-of-3 majority as the bit value. The bit ends on the tick where `tc` = OVERSAMPLE-1.
- States:
  - IDLE: on `rxs`=0 go to START, set `busy`, clear `tc`.
  - START: at the majority decision, a value of 1 is a false start and returns to IDLE with no outputs. At the end of the bit, go to DATA with bit index 0.
  - DATA: shift the majority bit into `shreg[7]`, shifting right. After bit index 7 ends, go to STOP.
  - STOP: at the majority decision, a value of 1 loads `data_out` from `shreg`, pulses `data_ready`, and goes to IDLE immediately without waiting for the rest of the stop bit. A value of 0 pulses `frame_error`, leaves `data_out` unchanged, and goes to BRK.
  - BRK: stay until `rxs`=1, then go to IDLE.
- `data_out` holds its value until the next good byte. Nothing is buffered; the consumer must take the byte on the `data_ready` cycle.
- `data_ready` and `frame_error` are never high at the same time.
- Reset in the middle of a byte discards the partial byte. Reception restarts only on a fresh falling edge seen after reset is released.

## Timing
- Reset values: `data_out`=0, `data_ready`=0, `frame_error`=0, `busy`=0. The state is IDLE and the synchroniser holds 1.
- Reference point T0 is the `clk` edge that first samples `com_RxD`=0. IDLE sees `rxs`=0 at T0+2.
- Start-bit middle: T0+2+(OVERSAMPLE/2+1)·DIVISOR.
- `data_ready` rises at T0 + 3 + (9·OVERSAMPLE + OVERSAMPLE/2 + 1)·DIVISOR. At the defaults this is T0+921, ±1 cycle for tick alignment. It stays high for exactly 1 cycle.
- `busy` falls in the same cycle `data_ready` rises.
- Back-to-back frames with a zero idle gap must be accepted, because IDLE re-arms about half a bit before the next start edge.
- The majority vote tolerates a single-cycle glitch on any one of the three samples.
- Clock-rate tolerance: ±4 % baud mismatch over a 10-bit frame must still decode correctly.

## Structure
- Shared include `uart_defs.v`: holds the state encodings (IDLE, START, DATA, STOP, BRK, width `RX_STATE_WIDTH`) and the default `CLK_FREQ`, `BAUD` and `OVERSAMPLE` localparams. The transmit side and the transfer controller include the same file.
- Sub-module `baud_tick_gen` takes `DIVISOR`, has a synchronous `restart` input, and produces the one-cycle `tick` output. It is reused by the transmitter.
- The majority vote, bit counter and shift register stay inline.

## Test plan
- Drive 0x70 at 115200 baud with default parameters. Expect exactly one `data_ready` pulse with `data_out`=0x70 at T0+921±1, `frame_error` never high, and `busy` high from T0+2 to the pulse.
- Drive a 12-cycle low glitch on an idle line. Expect START to reject it, `busy` to fall within 60 cycles, and no `data_ready` or `frame_error`.
- Drive 0x0F with the stop bit forced to 0, then hold the line low for 300 cycles and release it. Expect one `frame_error` pulse, `data_out` keeping its previous value, `busy` staying high until the line returns high, and a following 0x38 received correctly.
- Drive six bytes 0x01, 0x00, 0x20, 0x00, 0x40, 0x00 back-to-back with no idle gap. Expect six `data_ready` pulses carrying those values in order.
- Drive 0x93 at a baud rate 3 % fast, with one-cycle glitches placed on the first sample of each bit. Expect `data_out`=0x93 and no error.
- Assert `rst` for 2 cycles at data bit 4 of 0xF3. Expect all outputs 0 asynchronously, no pulse for that frame, and the next byte 0xF3 received correctly.
